systolic_tile_sequencer: RTL and testbench

- Parametrised FSM that sequences one complete weight-stationary tile of the systolic array: weight-buffer reads and weight-FIFO load, unified-buffer data streaming, matmul, result drain and accumulator capture.
- Replaces per-cycle instruction decoding with a single start/done handshake.
- Sits between the host-facing instruction logic and the buffer/FIFO/MMU/accumulator strobes; drives addresses and enables only, no datapath.

---
 rtl/systolic_tile_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_sequencer.sv
// Sequences one weight-stationary systolic tile: weight load, data stream, drain, accumulator capture.
// Optional busy-cycle counter on cycle_count is compiled in with TILE_SEQ_PERF_EN.
module systolic_tile_sequencer #(
  parameter int ARRAY_DIM  = 16,
  parameter int ADDR_W     = 8,
  parameter int ROWS_W     = 9,
  parameter int RESULT_LAT = 2*ARRAY_DIM+1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [ROWS_W-1:0] num_rows,
  output logic              busy,
  output logic              done,
  output logic              wb_rd_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              w_load,
  output logic              ub_rd_en,
  output logic [ADDR_W-1:0] ub_addr,
  output logic              mm_en,
  output logic              acc_en,
  output logic [31:0]       cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] LOAD_LAST  = 32'(ARRAY_DIM);
  localparam logic [31:0] DRAIN_LAST = 32'(RESULT_LAT - 1);
  localparam logic [31:0] RES_LAT    = 32'(RESULT_LAT);

  logic [2:0]        state_q, state_d;
  logic [31:0]       ph_q, ph_d;
  logic [31:0]       acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] d_base_q, d_base_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic [31:0]       rows_ext_s, rows_ext_d_s;
  logic              accept_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wb_rd_en_q, wb_rd_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              w_load_q, w_load_d;
  logic              ub_rd_en_q, ub_rd_en_d;
  logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
  logic              mm_en_q, mm_en_d;
  logic              acc_en_q, acc_en_d;

  assign rows_ext_s   = {{(32-ROWS_W){1'b0}}, rows_q};
  assign rows_ext_d_s = {{(32-ROWS_W){1'b0}}, rows_d};

  // Phase sequencing; the acc down-counter is armed with RESULT_LAT+N on entry to STREAM
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    w_base_d  = w_base_q;
    d_base_d  = d_base_q;
    rows_d    = rows_q;
    accept_s  = 1'b0;
    if (acc_cnt_q != 32'd0) begin
      acc_cnt_d = acc_cnt_q - 32'd1;
    end else begin
      acc_cnt_d = 32'd0;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          w_base_d = w_base;
          d_base_d = d_base;
          rows_d   = num_rows;
          ph_d     = 32'd0;
          if (num_rows == {ROWS_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_W;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (ph_q == LOAD_LAST) begin
          state_d   = S_STREAM;
          ph_d      = 32'd0;
          acc_cnt_d = RES_LAT + rows_ext_s;
        end else begin
          ph_d = ph_q + 32'd1;
        end
      end
      S_STREAM: begin
        if (ph_q == rows_ext_s - 32'd1) begin
          state_d = S_DRAIN;
          ph_d    = 32'd0;
        end else begin
          ph_d = ph_q + 32'd1;
        end
      end
      S_DRAIN: begin
        if (ph_q == DRAIN_LAST) begin
          state_d = S_DONE;
          ph_d    = 32'd0;
        end else begin
          ph_d = ph_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ph_d    = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = 32'd0;
      end
    endcase
  end

  // Output strobes decoded from the next state so every output can be registered
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    wb_rd_en_d = (state_d == S_LOAD_W) && (ph_d < LOAD_LAST);
    w_load_d   = (state_d == S_LOAD_W) && (ph_d != 32'd0);
    ub_rd_en_d = (state_d == S_STREAM);
    mm_en_d    = (state_d == S_STREAM) || (state_d == S_DRAIN);
    acc_en_d   = (acc_cnt_d != 32'd0) && (acc_cnt_d <= rows_ext_d_s);
    if (wb_rd_en_d) begin
      wb_addr_d = w_base_d + ph_d[ADDR_W-1:0];
    end else begin
      wb_addr_d = {ADDR_W{1'b0}};
    end
    if (ub_rd_en_d) begin
      ub_addr_d = d_base_d + ph_d[ADDR_W-1:0];
    end else begin
      ub_addr_d = {ADDR_W{1'b0}};
    end
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ph_q       <= 32'd0;
      acc_cnt_q  <= 32'd0;
      w_base_q   <= {ADDR_W{1'b0}};
      d_base_q   <= {ADDR_W{1'b0}};
      rows_q     <= {ROWS_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_rd_en_q <= 1'b0;
      wb_addr_q  <= {ADDR_W{1'b0}};
      w_load_q   <= 1'b0;
      ub_rd_en_q <= 1'b0;
      ub_addr_q  <= {ADDR_W{1'b0}};
      mm_en_q    <= 1'b0;
      acc_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      acc_cnt_q  <= acc_cnt_d;
      w_base_q   <= w_base_d;
      d_base_q   <= d_base_d;
      rows_q     <= rows_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wb_rd_en_q <= wb_rd_en_d;
      wb_addr_q  <= wb_addr_d;
      w_load_q   <= w_load_d;
      ub_rd_en_q <= ub_rd_en_d;
      ub_addr_q  <= ub_addr_d;
      mm_en_q    <= mm_en_d;
      acc_en_q   <= acc_en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wb_rd_en = wb_rd_en_q;
  assign wb_addr  = wb_addr_q;
  assign w_load   = w_load_q;
  assign ub_rd_en = ub_rd_en_q;
  assign ub_addr  = ub_addr_q;
  assign mm_en    = mm_en_q;
  assign acc_en   = acc_en_q;

`ifdef TILE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  // Saturating busy-cycle counter; the result is published on the DONE cycle
  always_comb begin
    if (accept_s) begin
      perf_d = 32'd1;
    end else if ((state_d != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
    if (state_d == S_DONE) begin
      cycle_count_d = perf_d;
    end else if (accept_s) begin
      cycle_count_d = 32'd0;
    end else begin
      cycle_count_d = cycle_count_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q        <= 32'd0;
      cycle_count_q <= 32'd0;
    end else begin
      perf_q        <= perf_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Self-checking bench for systolic_tile_sequencer: per-cycle strobe traces against a
// tile-timeline model, plus reset, zero-row, ignored-start and back-to-back scenarios.
module tb_systolic_tile_sequencer;

  localparam int AD = 16;
  localparam int RL = 2*AD+1;
`ifdef TILE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  w_base;
  logic [7:0]  d_base;
  logic [8:0]  num_rows;
  logic        busy, done, wb_rd_en, w_load, ub_rd_en, mm_en, acc_en;
  logic [7:0]  wb_addr, ub_addr;
  logic [31:0] cycle_count;

  int total = 0;
  int bad   = 0;

  systolic_tile_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .w_base(w_base), .d_base(d_base), .num_rows(num_rows),
    .busy(busy), .done(done), .wb_rd_en(wb_rd_en), .wb_addr(wb_addr),
    .w_load(w_load), .ub_rd_en(ub_rd_en), .ub_addr(ub_addr),
    .mm_en(mm_en), .acc_en(acc_en), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs on busy cycle t of a tile (t=0 is the cycle after acceptance).
  function automatic logic [22:0] exp_vec(int t, logic [7:0] wb, logic [7:0] db, int n);
    int ls, dn;
    logic b, d, wre, wl, ure, mm, acc;
    logic [7:0] wa, ua;
    ls = AD + 1;
    dn = (n == 0) ? 0 : ls + n + RL;
    b = (t <= dn); d = (t == dn);
    wre = 1'b0; wl = 1'b0; ure = 1'b0; mm = 1'b0; acc = 1'b0; wa = 8'h00; ua = 8'h00;
    if (n > 0) begin
      wre = (t < AD);
      if (wre) wa = wb + 8'(t);
      wl  = (t >= 1) && (t <= AD);
      ure = (t >= ls) && (t < ls + n);
      if (ure) ua = db + 8'(t - ls);
      mm  = (t >= ls) && (t < ls + n + RL);
      acc = (t >= ls + RL) && (t < ls + RL + n);
    end
    return {b, d, wre, wa, wl, ure, ua, mm, acc};
  endfunction

  function automatic logic [22:0] obs();
    return {busy, done, wb_rd_en, (wb_rd_en ? wb_addr : 8'h00), w_load,
            ub_rd_en, (ub_rd_en ? ub_addr : 8'h00), mm_en, acc_en};
  endfunction

  task automatic run_tile(input logic [7:0] wb, input logic [7:0] db, input int n,
                          input bit noise, input bit immediate);
    int len;
    logic [22:0] e, o;
    logic [31:0] exp_cc;
    len = (n == 0) ? 1 : AD + 1 + n + RL + 1;
    exp_cc = PERF ? 32'(len) : 32'd0;
    if (!immediate) @(negedge clk);
    start = 1'b1; w_base = wb; d_base = db; num_rows = 9'(n);
    @(negedge clk);
    for (int t = 0; t < len; t++) begin
      e = exp_vec(t, wb, db, n);
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL trace t=%0d got=%h exp=%h (wb=%h db=%h n=%0d)", t, o, e, wb, db, n);
      end
      if (t == len - 1) begin
        total++;
        if (cycle_count !== exp_cc) begin
          bad++;
          $display("FAIL cycle_count_done got=%0d exp=%0d n=%0d", cycle_count, exp_cc, n);
        end
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        w_base = 8'($urandom); d_base = 8'($urandom); num_rows = 9'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (obs() !== 23'd0 || cycle_count !== exp_cc) begin
      bad++;
      $display("FAIL idle_after_tile got=%h cc=%0d exp=0 cc=%0d n=%0d", obs(), cycle_count, exp_cc, n);
    end
  endtask

  task automatic test_reset_power_on();
    total++;
    if (obs() !== 23'd0 || cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got=%h cc=%0d exp=0", obs(), cycle_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    int dones, busies;
    @(negedge clk);
    start = 1'b1; w_base = 8'h00; d_base = 8'h20; num_rows = 9'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (AD + 2) @(negedge clk);
    total++;
    if (ub_rd_en !== 1'b1 || ub_addr !== 8'h21) begin
      bad++;
      $display("FAIL second_stream_cycle got ub_rd_en=%b ub_addr=%h exp 1/21", ub_rd_en, ub_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (obs() !== 23'd0 || cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_drop got=%h cc=%0d exp=0", obs(), cycle_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0; busies = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) busies++;
    end
    total++;
    if (dones !== 0 || busies !== 0) begin
      bad++;
      $display("FAIL post_reset_idle got dones=%0d busy_cycles=%0d exp 0/0", dones, busies);
    end
  endtask

  task automatic test_basic();
    run_tile(8'h10, 8'h40, 4, 1'b0, 1'b0);
  endtask

  task automatic test_long_stream();
    run_tile(8'h00, 8'h80, 40, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_tile(8'hFE, 8'hFF, 2, 1'b0, 1'b0);
  endtask

  task automatic test_zero_rows();
    run_tile(8'h12, 8'h34, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_tile(8'h33, 8'h44, 4, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_tile(8'hA0, 8'hB0, 3, 1'b0, 1'b0);
    run_tile(8'h01, 8'h02, 0, 1'b0, 1'b1);
    run_tile(8'hF8, 8'hFC, 5, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_tile(8'($urandom), 8'($urandom), int'($urandom_range(0, 60)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; w_base = 8'h00; d_base = 8'h00; num_rows = 9'd0;
    #23;
    test_reset_power_on();
    test_basic();
    test_long_stream();
    test_wrap();
    test_zero_rows();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
